// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with registered count/flags, sticky errors and flush.
// Latency: standard mode 1 cycle from accepted read to rd_data; FWFT mode head visible combinationally.
// Backpressure: writes refused while full (sets overflow), reads refused while empty (sets underflow).
//
// Optional feature: define SYNC_FIFO_FWFT_EN for first-word fall-through read mode.
// Ports:
//   i_clk, i_rst (sync, active-high), i_flush, i_clr_err
//   i_wr_en/i_wr_data   write side
//   i_rd_en, o_rd_data, o_rd_valid   read side
//   o_full, o_empty, o_almost_full, o_almost_empty, o_count   status (registered)
//   o_overflow, o_underflow   sticky error flags
module sync_fifo_param #(
    parameter int DATA_WIDTH    = 4,
    parameter int ADDR_WIDTH    = 3,
    parameter int AFULL_THRESH  = 6,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_flush,
    input  logic                  i_wr_en,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic                  i_clr_err,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_rd_valid,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_almost_full,
    output logic                  o_almost_empty,
    output logic [ADDR_WIDTH:0]   o_count,
    output logic                  o_overflow,
    output logic                  o_underflow
);

    localparam int                DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] C_DEPTH  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] C_AFULL  = (ADDR_WIDTH+1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0] C_AEMPTY = (ADDR_WIDTH+1)'(AEMPTY_THRESH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wptr;
    logic [ADDR_WIDTH-1:0] r_rptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_afull;
    logic                  r_aempty;
    logic                  r_ovf;
    logic                  r_udf;

    logic                  w_wa;
    logic                  w_ra;
    logic [ADDR_WIDTH:0]   w_count_nxt;

    // Acceptance uses the registered flags only, so there is no
    // combinational path from the request inputs to any status output.
    assign w_wa = i_wr_en & ~r_full;
    assign w_ra = i_rd_en & ~r_empty;

    always_comb begin
        w_count_nxt = r_count;
        if (i_flush) begin
            w_count_nxt = '0;
        end else if (w_wa && !w_ra) begin
            w_count_nxt = r_count + 1'b1;
        end else if (w_ra && !w_wa) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    // Storage is deliberately not reset or flushed; pointers define validity.
    always_ff @(posedge i_clk) begin
        if (!i_rst && !i_flush && w_wa) begin
            r_mem[r_wptr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_afull  <= 1'b0;
            r_aempty <= 1'b1;
        end else begin
            if (i_flush) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else begin
                if (w_wa) r_wptr <= r_wptr + 1'b1;
                if (w_ra) r_rptr <= r_rptr + 1'b1;
            end
            // Flags follow the next-state count so they move on the same edge as o_count.
            r_count  <= w_count_nxt;
            r_full   <= (w_count_nxt == C_DEPTH);
            r_empty  <= (w_count_nxt == '0);
            r_afull  <= (w_count_nxt >= C_AFULL);
            r_aempty <= (w_count_nxt <= C_AEMPTY);
        end
    end

    // Sticky errors: a set in the same cycle as clr_err wins. Requests in a
    // flush cycle are ignored, so they cannot raise an error either.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            if (i_wr_en && r_full && !i_flush) r_ovf <= 1'b1;
            else if (i_clr_err)                r_ovf <= 1'b0;
            if (i_rd_en && r_empty && !i_flush) r_udf <= 1'b1;
            else if (i_clr_err)                 r_udf <= 1'b0;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    logic [DATA_WIDTH-1:0] w_rd_data;

    // Head word is presented directly; forced to zero while nothing is stored.
    assign w_rd_data  = r_empty ? '0 : r_mem[r_rptr];
    assign o_rd_data  = w_rd_data;
    assign o_rd_valid = ~r_empty;
`else
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_rd_valid;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else if (i_flush) begin
            r_rd_valid <= 1'b0;
        end else if (w_ra) begin
            r_rd_data  <= r_mem[r_rptr];
            r_rd_valid <= 1'b1;
        end else begin
            r_rd_valid <= 1'b0;
        end
    end

    assign o_rd_data  = r_rd_data;
    assign o_rd_valid = r_rd_valid;
`endif

    assign o_full         = r_full;
    assign o_empty        = r_empty;
    assign o_almost_full  = r_afull;
    assign o_almost_empty = r_aempty;
    assign o_count        = r_count;
    assign o_overflow     = r_ovf;
    assign o_underflow    = r_udf;

endmodule
